// File: rtl/alu_ctrl_muldiv_unit.sv
// ALU control decoder with an iterative signed/unsigned multiply/divide engine and HI/LO registers.
// The engine computes on operand magnitudes one bit per cycle and applies result signs on write-back.
module alu_ctrl_muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic             op_valid,
   input  logic             flush,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [3:0]       alu_ctr,
   output logic [WIDTH-1:0] hilo_data,
   output logic             stall,
   output logic             md_busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_q, acc_d; // product high half or partial remainder
   logic [WIDTH-1:0] q_q, q_d;     // multiplier/product low half or dividend/quotient
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             neg_r_q, neg_r_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic is_mfhi, is_mflo, md_op, hl_op, issue;
   logic signed_op;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, div_rem, div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] quot, rem;

   always_comb begin
      alu_ctr = 4'b0010;
      unique case (alu_op)
         4'b0000: alu_ctr = 4'b0010;
         4'b0001: alu_ctr = 4'b0110;
         4'b0010: alu_ctr = 4'b0000;
         4'b0011: alu_ctr = 4'b0001;
         4'b0100: alu_ctr = 4'b0100;
         4'b0101: alu_ctr = 4'b0111;
         4'b1101: alu_ctr = 4'b1111;
         4'b1000: alu_ctr = 4'b1000;
         4'b0111: begin
            unique case (funct)
               6'b100000, 6'b100001: alu_ctr = 4'b0010;
               6'b100010, 6'b100011: alu_ctr = 4'b0110;
               6'b100100:            alu_ctr = 4'b0000;
               6'b100101:            alu_ctr = 4'b0001;
               6'b100110:            alu_ctr = 4'b0100;
               6'b100111:            alu_ctr = 4'b0101;
               6'b101010:            alu_ctr = 4'b0111;
               6'b101011:            alu_ctr = 4'b1111;
               6'b000000, 6'b000100: alu_ctr = 4'b1000;
               6'b000010, 6'b000110: alu_ctr = 4'b1001;
               6'b000011, 6'b000111: alu_ctr = 4'b1010;
               6'b011000, 6'b011001: alu_ctr = 4'b1011;
               6'b011010, 6'b011011: alu_ctr = 4'b1100;
               default:              alu_ctr = 4'b0010;
            endcase
         end
         default: alu_ctr = 4'b0010;
      endcase
   end

   assign is_mfhi   = (alu_op == 4'b0110) && (funct == 6'b001010);
   assign is_mflo   = (alu_op == 4'b0110) && (funct == 6'b001100);
   assign md_op     = op_valid && (alu_op == 4'b0111) && (funct[5:2] == 4'b0110);
   assign hl_op     = op_valid && (is_mfhi || is_mflo);
   assign md_busy   = (state_q != StIdle);
   assign stall     = md_busy && (md_op || hl_op);
   assign issue     = md_op && !md_busy && !flush;
   assign hilo_data = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
   assign hi        = hi_q;
   assign lo        = lo_q;

   // funct[0]==0 selects the signed variant, funct[1]==1 selects divide
   assign signed_op = !funct[0];
   assign mag_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

   assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, a_q} : '0);
   assign div_rem  = {acc_q, q_q[WIDTH-1]};
   assign div_diff = div_rem - {1'b0, a_q};

   assign prod = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
   assign quot = div0_q ? '1 : (neg_q ? -q_q : q_q);
   assign rem  = neg_r_q ? -acc_q : acc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      acc_d   = acc_q;
      q_d     = q_q;
      div_d   = div_q;
      neg_d   = neg_q;
      neg_r_d = neg_r_q;
      div0_d  = div0_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      md_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StRun;
               cnt_d   = CNT_W'(WIDTH);
               div_d   = funct[1];
               a_d     = funct[1] ? mag_b : mag_a;
               q_d     = funct[1] ? mag_a : mag_b;
               acc_d   = '0;
               neg_d   = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
               neg_r_d = signed_op && src_a[WIDTH-1];
               div0_d  = funct[1] && (src_b == '0);
            end
         end
         StRun: begin
            if (flush) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               if (div_q) begin
                  // Restoring step: keep the difference unless it borrowed
                  if (!div_diff[WIDTH]) begin
                     acc_d = div_diff[WIDTH-1:0];
                     q_d   = {q_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d = div_rem[WIDTH-1:0];
                     q_d   = {q_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d = mul_sum[WIDTH:1];
                  q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
            if (!flush) begin
               md_done = 1'b1;
               if (div_q) begin
                  hi_d = rem;
                  lo_d = quot;
               end else begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         neg_r_q <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         neg_r_q <= neg_r_d;
         div0_q  <= div0_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_muldiv_unit.sv
// Self-checking bench for alu_ctrl_muldiv_unit: decode table, directed and random mul/div
// against an arithmetic reference, plus stall, flush and asynchronous reset sequences.
module tb_alu_ctrl_muldiv_unit;
   localparam int W = 32;
   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;
   localparam logic [5:0] F_MFHI = 6'b001010, F_MFLO = 6'b001100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   alu_op;
   logic [5:0]   funct;
   logic         op_valid, flush;
   logic [W-1:0] src_a, src_b;
   logic [3:0]   alu_ctr;
   logic [W-1:0] hilo_data, hi, lo;
   logic         stall, md_busy, md_done;

   alu_ctrl_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .op_valid(op_valid),
      .flush(flush), .src_a(src_a), .src_b(src_b), .alu_ctr(alu_ctr), .hilo_data(hilo_data),
      .stall(stall), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Reference: plain signed/unsigned arithmetic on 64-bit integers
   function automatic void ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rhi, output logic [W-1:0] rlo);
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      rhi = '0;
      rlo = '0;
      case (f)
         F_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {rhi, rlo} = sp;
         end
         F_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {rhi, rlo} = up;
         end
         F_DIV: begin
            if (b == 0) begin
               rlo = '1; rhi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               rlo = a; rhi = '0;
            end else begin
               sa = a; sb = b;
               rlo = sa / sb; rhi = sa % sb;
            end
         end
         default: begin
            if (b == 0) begin
               rlo = '1; rhi = a;
            end else begin
               rlo = a / b; rhi = a % b;
            end
         end
      endcase
   endfunction

   // Issues one mul/div, scrambles operands afterwards, returns cycles from issue to md_done
   task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'b0111; funct = f; src_a = a; src_b = b;
      @(posedge clk);
      #1 op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (md_done) begin
            lat = k;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] op;
      logic [5:0] f;
      logic [3:0] exp;
   } dec_vec_t;

   typedef struct {
      logic [5:0]   f;
      logic [W-1:0] a, b, ehi, elo;
   } md_vec_t;

   dec_vec_t dec_tbl[$];
   md_vec_t  md_tbl[$];

   initial begin
      int lat, bad, seen, dcnt;
      logic [5:0]   rf;
      logic [W-1:0] ra, rb, ehi, elo;
      logic [5:0]   fsel[4];

      dec_tbl = '{
         '{4'b0000, 6'h00, 4'b0010}, '{4'b0001, 6'h15, 4'b0110}, '{4'b0010, 6'h3f, 4'b0000},
         '{4'b0011, 6'h00, 4'b0001}, '{4'b0100, 6'h21, 4'b0100}, '{4'b0101, 6'h00, 4'b0111},
         '{4'b1101, 6'h00, 4'b1111}, '{4'b1000, 6'h11, 4'b1000}, '{4'b0110, F_MFHI, 4'b0010},
         '{4'b0110, F_MFLO, 4'b0010}, '{4'b1111, 6'h20, 4'b0010}, '{4'b0110, 6'h00, 4'b0010},
         '{4'b0111, 6'b100000, 4'b0010}, '{4'b0111, 6'b100001, 4'b0010},
         '{4'b0111, 6'b100010, 4'b0110}, '{4'b0111, 6'b100011, 4'b0110},
         '{4'b0111, 6'b100100, 4'b0000}, '{4'b0111, 6'b100101, 4'b0001},
         '{4'b0111, 6'b100110, 4'b0100}, '{4'b0111, 6'b100111, 4'b0101},
         '{4'b0111, 6'b101010, 4'b0111}, '{4'b0111, 6'b101011, 4'b1111},
         '{4'b0111, 6'b000000, 4'b1000}, '{4'b0111, 6'b000100, 4'b1000},
         '{4'b0111, 6'b000010, 4'b1001}, '{4'b0111, 6'b000110, 4'b1001},
         '{4'b0111, 6'b000011, 4'b1010}, '{4'b0111, 6'b000111, 4'b1010},
         '{4'b0111, F_MULT, 4'b1011}, '{4'b0111, F_MULTU, 4'b1011},
         '{4'b0111, F_DIV, 4'b1100}, '{4'b0111, F_DIVU, 4'b1100},
         '{4'b0111, 6'b101111, 4'b0010}, '{4'b0111, 6'b001000, 4'b0010}
      };
      md_tbl = '{
         '{F_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
         '{F_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA},
         '{F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
         '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000},
         '{F_DIVU,  32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF},
         '{F_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF}
      };
      fsel = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

      rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; alu_op = 4'b0110; funct = F_MFLO;
      src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      op_valid = 1'b1;
      #1;
      chk("rst_busy", md_busy, 0); chk("rst_done", md_done, 0); chk("rst_stall", stall, 0);
      chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_hilo_data", hilo_data, 0);
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (dec_tbl[i]) begin
         @(negedge clk);
         alu_op = dec_tbl[i].op; funct = dec_tbl[i].f;
         #1 chk($sformatf("decode_%b_%b", dec_tbl[i].op, dec_tbl[i].f), alu_ctr, dec_tbl[i].exp);
      end

      foreach (md_tbl[i]) begin
         run_md(md_tbl[i].f, md_tbl[i].a, md_tbl[i].b, lat);
         chk($sformatf("dir%0d_latency", i), lat, 33);
         chk($sformatf("dir%0d_hi", i), hi, md_tbl[i].ehi);
         chk($sformatf("dir%0d_lo", i), lo, md_tbl[i].elo);
      end

      for (int i = 0; i < 16; i++) begin
         rf = fsel[$urandom_range(0, 3)];
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
         if (i[1:0] == 2'd1) rb = rb >> $urandom_range(0, 28);
         ref_md(rf, ra, rb, ehi, elo);
         run_md(rf, ra, rb, lat);
         chk($sformatf("rnd%0d_latency", i), lat, 33);
         chk($sformatf("rnd%0d_hi", i), hi, ehi);
         chk($sformatf("rnd%0d_lo", i), lo, elo);
      end

      // mflo two cycles after a div issue waits for the result
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'b0111; funct = F_DIV; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(posedge clk);
      #1 op_valid = 1'b1; alu_op = 4'b0110; funct = F_MFLO;
      bad = 0; seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!stall) bad++;
         if (md_done) begin
            seen = 1;
            break;
         end
      end
      chk("mflo_stall_held", bad, 0); chk("mflo_done_seen", seen, 1);
      @(negedge clk);
      chk("mflo_stall_released", stall, 0); chk("mflo_data", hilo_data, 32'd14);
      funct = F_MFHI;
      #1 chk("mfhi_data", hilo_data, 32'd2);
      @(posedge clk);
      #1 op_valid = 1'b0;

      // A second mult while busy is held off and issues right after md_done
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'b0111; funct = F_MULT; src_a = 32'd5; src_b = 32'd6;
      @(posedge clk);
      #1 op_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 op_valid = 1'b1; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
      bad = 0; seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!stall) bad++;
         if (md_done) begin
            seen = 1;
            break;
         end
      end
      chk("second_stall_held", bad, 0); chk("second_first_done", seen, 1);
      @(negedge clk);
      chk("second_stall_drop", stall, 0); chk("second_idle_gap", md_busy, 0);
      chk("first_lo", lo, 32'd30); chk("first_hi", hi, 32'd0);
      @(posedge clk);
      #1 op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
      @(negedge clk);
      chk("second_busy_reassert", md_busy, 1);
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (md_done) begin
            seen = 1;
            break;
         end
      end
      chk("second_done_seen", seen, 1);
      @(posedge clk);
      #1;
      chk("second_hi", hi, 32'hFFFF_FFFF); chk("second_lo", lo, 32'hFFFF_FFEB);

      // Flush partway through RUN discards the operation
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'b0111; funct = F_MULTU; src_a = 32'd123; src_b = 32'd456;
      @(posedge clk);
      #1 op_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_idle", md_busy, 0);
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_done) dcnt++;
      end
      chk("flush_no_done", dcnt, 0);
      chk("flush_hi_kept", hi, 32'hFFFF_FFFF); chk("flush_lo_kept", lo, 32'hFFFF_FFEB);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'b0111; funct = F_MULT; src_a = 32'd3; src_b = 32'd4;
      @(posedge clk);
      #1 op_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 op_valid = 1'b1;
      #1 chk("prereset_stall", stall, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", md_busy, 0); chk("arst_done", md_done, 0); chk("arst_stall", stall, 0);
      chk("arst_hi", hi, 0); chk("arst_lo", lo, 0);
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_md(F_MULTU, 32'd3, 32'd4, lat);
      chk("post_reset_latency", lat, 33); chk("post_reset_lo", lo, 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
